// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// The transmitter imports these too.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// The reset value is a parameter so idle-high lines stay quiet through reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DBIT data bits LSB first, stop bit.
// Delivers each word with a one-cycle done strobe and a framing-error flag.
//
// state | meaning
// IDLE  | line high, waiting for a low level on rx_s
// START | counting to the start-bit midpoint, rejecting glitches
// DATA  | sampling one data bit every 16 ticks
// STOP  | waiting SB_TICK ticks, then sampling the stop bit
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx,
   input  logic            s_tick,
   output logic            rx_done_tick,
   output logic [DBIT-1:0] dout,
   output logic            frame_err
);
   localparam int SW = (cnt_width(SB_TICK) > 5) ? cnt_width(SB_TICK) : 5;
   localparam int NW = cnt_width(DBIT);

   localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
   localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   rx_state_t       state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic [DBIT-1:0] dout_next;
   logic            ferr_next, done_next;
   logic            rx_s;

   sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         s_reg        <= '0;
         n_reg        <= '0;
         b_reg        <= '0;
         dout         <= '0;
         frame_err    <= 1'b0;
         rx_done_tick <= 1'b0;
      end else begin
         state_reg    <= state_next;
         s_reg        <= s_next;
         n_reg        <= n_next;
         b_reg        <= b_next;
         dout         <= dout_next;
         frame_err    <= ferr_next;
         rx_done_tick <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      dout_next  = dout;
      ferr_next  = frame_err;
      done_next  = 1'b0;

      unique case (state_reg)
         IDLE: begin
            // A tick coinciding with this transition is deliberately not counted.
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == S_MID) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == S_BIT) begin
                  s_next = '0;
                  b_next = {rx_s, b_reg[DBIT-1:1]};
                  if (n_reg == N_LAST) state_next = STOP;
                  else                 n_next     = n_reg + 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_reg == S_STOP) begin
                  dout_next  = b_reg;
                  ferr_next  = ~rx_s;
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames into two receivers (8N1/16 and 7-bit/32-tick stop),
// compared against word, error flag and strobe timing computed from the frame rules.
module tb_uart_rx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       s_tick = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic       rx_done_a, rx_done_b;
   logic [7:0] dout_a;
   logic [6:0] dout_b;
   logic       frame_err_a, frame_err_b;

   int checks = 0;
   int failures = 0;
   int tick_cnt = 0;
   int na = 0;
   int nb = 0;

   typedef struct {
      logic [7:0] d;
      logic       e;
      int         t;
   } strobe_t;

   strobe_t qa[$];
   strobe_t qb[$];

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut_a (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx_a),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_a),
      .dout         (dout_a),
      .frame_err    (frame_err_a)
   );

   uart_rx #(.DBIT(7), .SB_TICK(32)) dut_b (
      .clk          (clk),
      .reset        (reset),
      .rx           (rx_b),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_b),
      .dout         (dout_b),
      .frame_err    (frame_err_b)
   );

   always #5 clk = ~clk;

   // One tick every 10 clocks, changed on the falling edge.
   initial begin
      forever begin
         repeat (9) @(negedge clk);
         s_tick = 1'b1;
         @(negedge clk);
         s_tick = 1'b0;
      end
   end

   always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

   always @(negedge clk) begin
      if (rx_done_a === 1'b1) begin
         qa.push_back('{dout_a, frame_err_a, tick_cnt});
         na++;
      end
      if (rx_done_b === 1'b1) begin
         qb.push_back('{{1'b0, dout_b}, frame_err_b, tick_cnt});
         nb++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns just after the k-th following tick edge.
   task automatic wait_ticks(input int k);
      repeat (k) begin
         @(posedge clk);
         while (s_tick !== 1'b1) @(posedge clk);
      end
      #1;
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
   endtask

   // Bad stop bits are held low only for 10 ticks: long enough to cover the
   // stop sample point, short enough that the line is back high afterwards.
   task automatic send_frame(input bit sel, input logic [7:0] data, input int dbit,
                             input int sbt, input bit good_stop, output int final_tick);
      int edge_t;
      drive(sel, 1'b0);
      edge_t = tick_cnt;
      wait_ticks(16);
      for (int i = 0; i < dbit; i++) begin
         drive(sel, data[i]);
         wait_ticks(16);
      end
      drive(sel, good_stop);
      wait_ticks(good_stop ? sbt : 10);
      drive(sel, 1'b1);
      final_tick = edge_t + 8 + 16 * dbit + sbt;
   endtask

   task automatic expect_frame(input bit sel, input string tag, input logic [7:0] d,
                               input logic e, input int t);
      strobe_t got;
      int waited = 0;
      while (((sel ? qb.size() : qa.size()) == 0) && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      chk({tag, "_strobe"}, (sel ? qb.size() : qa.size()) != 0, 1);
      if ((sel ? qb.size() : qa.size()) != 0) begin
         got = sel ? qb.pop_front() : qa.pop_front();
         chk({tag, "_dout"}, got.d, d);
         chk({tag, "_ferr"}, got.e, e);
         chk({tag, "_tick"}, got.t, t);
      end
   endtask

   initial begin
      int ft;
      int exp_na;
      logic [7:0] d;
      bit good;

      exp_na = 0;
      repeat (5) @(negedge clk);
      chk("rst_dout_a", dout_a, 0);
      chk("rst_ferr_a", frame_err_a, 0);
      chk("rst_done_a", rx_done_a, 0);
      chk("rst_dout_b", dout_b, 0);
      reset = 1'b0;
      wait_ticks(3);

      send_frame(0, 8'hA5, 8, 16, 1, ft);
      expect_frame(0, "nominal", 8'hA5, 0, ft); exp_na++;
      wait_ticks(4);

      send_frame(0, 8'h3C, 8, 16, 0, ft);
      expect_frame(0, "ferr", 8'h3C, 1, ft); exp_na++;
      chk("ferr_held", frame_err_a, 1);
      wait_ticks(10);
      send_frame(0, 8'h3C, 8, 16, 1, ft);
      expect_frame(0, "ferr_clear", 8'h3C, 0, ft); exp_na++;
      wait_ticks(4);

      rx_a = 1'b0;
      wait_ticks(4);
      rx_a = 1'b1;
      wait_ticks(20);
      chk("false_start_nostrobe", qa.size(), 0);
      chk("false_start_dout", dout_a, 8'h3C);
      send_frame(0, 8'h81, 8, 16, 1, ft);
      expect_frame(0, "after_false", 8'h81, 0, ft); exp_na++;
      wait_ticks(4);

      send_frame(0, 8'h00, 8, 16, 1, ft);
      expect_frame(0, "b2b_first", 8'h00, 0, ft); exp_na++;
      send_frame(0, 8'hFF, 8, 16, 1, ft);
      expect_frame(0, "b2b_second", 8'hFF, 0, ft); exp_na++;
      wait_ticks(4);

      d = 8'h55;
      rx_a = 1'b0;
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         rx_a = d[i];
         wait_ticks(16);
      end
      rx_a = d[4];
      wait_ticks(8);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_dout", dout_a, 0);
      chk("midrst_ferr", frame_err_a, 0);
      chk("midrst_done", rx_done_a, 0);
      repeat (3) @(negedge clk);
      rx_a = 1'b1;
      reset = 1'b0;
      wait_ticks(20);
      chk("midrst_nostrobe", qa.size(), 0);
      send_frame(0, 8'h6E, 8, 16, 1, ft);
      expect_frame(0, "after_rst", 8'h6E, 0, ft); exp_na++;

      for (int k = 0; k < 10; k++) begin
         d    = 8'($urandom);
         good = ($urandom_range(3) != 0);
         send_frame(0, d, 8, 16, good, ft);
         expect_frame(0, "rand", d, !good, ft); exp_na++;
         wait_ticks(good ? $urandom_range(3) : 8 + $urandom_range(7));
      end

      send_frame(1, 8'h5A, 7, 32, 1, ft);
      expect_frame(1, "var7", 8'h5A, 0, ft);
      wait_ticks(4);

      chk("count_a", na, exp_na);
      chk("count_b", nb, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
